// File: rtl/bus_pkg.sv
// Shared types and constants for the serial-bus arbiter.
// State encoding and address-field positions.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int ADDR_BITS   = 16;
  localparam int SLV_SEL_MSB = 15;
  localparam int SLV_SEL_LSB = 14;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master/slave side bundle of the serial-bus arbiter.
// The arbiter connects through the slave modport.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3
);
  logic [N_MASTERS-1:0] M_BREQ;
  logic [N_MASTERS-1:0] M_BGRANT;
  logic [N_MASTERS-1:0] M_RW;
  logic [N_MASTERS-1:0] M_BUS_OUT;
  logic [N_MASTERS-1:0] M_BUS_IN;
  logic [N_MASTERS-1:0] M_ACK;
  logic [N_SLAVES-1:0]  S_AD_SEL;
  logic [N_SLAVES-1:0]  S_BUS_IN;
  logic [N_SLAVES-1:0]  S_ACK;
  logic [N_SLAVES-1:0]  S_SBSY;
  logic                 B_RW;
  logic                 B_BUS_OUT;
  logic                 BUS_BUSY;
  logic                 ARB_ERR;

  modport slave (
    input  M_BREQ, M_RW, M_BUS_OUT,
    input  S_BUS_IN, S_ACK, S_SBSY,
    output M_BGRANT, M_BUS_IN, M_ACK,
    output S_AD_SEL, B_RW, B_BUS_OUT,
    output BUS_BUSY, ARB_ERR
  );

  modport master (
    output M_BREQ, M_RW, M_BUS_OUT,
    output S_BUS_IN, S_ACK, S_SBSY,
    input  M_BGRANT, M_BUS_IN, M_ACK,
    input  S_AD_SEL, B_RW, B_BUS_OUT,
    input  BUS_BUSY, ARB_ERR
  );
endinterface

// File: rtl/counter.sv
// Up counter with synchronous clear, shared by address
// bit counting and the data-phase timeout.
module counter #(
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rst,
  input  logic             i_incr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_count <= '0;
    else if (i_rst)  r_count <= '0;
    else if (i_incr) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin serial-bus arbiter: grants one master, decodes the
// slave from address bits [15:14] and routes data until release.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS    = 2,
  parameter int N_SLAVES     = 3,
  parameter int DATA_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 7
) (
  input logic          CLK,
  input logic          RSTN,
  bus_arbiter_if.slave bus
);

  arb_state_t           r_state, w_next;
  logic [N_MASTERS-1:0] r_gnt;
  logic [N_SLAVES-1:0]  r_sel_oh, w_dec, w_sel;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic [1:0]           w_idx;
  logic r_gidx, r_last, r_addr14, r_seen;
  logic w_act, w_abort, w_last_a, w_mapped;
  logic w_sbsy, w_done, w_tmo, w_win, w_cnt_rst;
  logic w_sbit, w_sack;

  counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_rst   (w_cnt_rst),
    .i_incr  (1'b1),
    .o_count (w_cnt)
  );

  assign w_act    = (r_state == ADDR) || (r_state == DATA);
  assign w_abort  = w_act && !bus.M_BREQ[r_gidx];
  assign w_last_a = (r_state == ADDR) &&
                    (w_cnt == CNT_WIDTH'(ADDR_BITS - 1));
  assign w_idx    = {bus.M_BUS_OUT[r_gidx], r_addr14};

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (w_idx == 2'(i)) w_dec[i] = 1'b1;
  end

  assign w_mapped = |w_dec;
  assign w_sbsy   = |(bus.S_SBSY & r_sel_oh);
  assign w_sbit   = |(bus.S_BUS_IN & r_sel_oh);
  assign w_sack   = |(bus.S_ACK & r_sel_oh);
  assign w_done   = (r_state == DATA) && r_seen && !w_sbsy;
  assign w_tmo    = (r_state == DATA) && !w_done &&
                    (w_cnt == CNT_WIDTH'(DATA_TIMEOUT - 1));
  // Tie goes to the master that was not granted last.
  assign w_win    = (&bus.M_BREQ) ? ~r_last : bus.M_BREQ[1];
  assign w_cnt_rst = !w_act || (w_next != r_state);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (|bus.M_BREQ) w_next = ADDR;
      ADDR: begin
        if (w_abort || (w_last_a && !w_mapped)) w_next = RELEASE;
        else if (w_last_a)                       w_next = DATA;
      end
      DATA: if (w_abort || w_done || w_tmo) w_next = RELEASE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sel = '0;
    if (w_abort)                w_sel = '0;
    else if (r_state == ADDR)   w_sel = w_last_a ? w_dec : '1;
    else if (r_state == DATA)   w_sel = r_sel_oh;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gidx   <= 1'b0;
      r_last   <= 1'b1;
      r_addr14 <= 1'b0;
      r_seen   <= 1'b0;
      r_sel_oh <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (|bus.M_BREQ) begin
          r_gidx <= w_win;
          r_gnt  <= N_MASTERS'(1) << w_win;
        end
        ADDR: begin
          if (w_cnt == CNT_WIDTH'(SLV_SEL_LSB))
            r_addr14 <= bus.M_BUS_OUT[r_gidx];
          if (w_last_a) r_sel_oh <= w_dec;
          r_seen <= 1'b0;
        end
        DATA:    if (w_sbsy) r_seen <= 1'b1;
        RELEASE: r_last <= r_gidx;
        default: ;
      endcase
      if (w_next == RELEASE) r_gnt <= '0;
    end
  end

  assign bus.M_BGRANT  = r_gnt;
  assign bus.S_AD_SEL  = w_sel;
  assign bus.B_RW      = w_act && bus.M_RW[r_gidx];
  assign bus.B_BUS_OUT = w_act && bus.M_BUS_OUT[r_gidx];
  assign bus.M_BUS_IN  = ((r_state == DATA) && w_sbit) ? r_gnt : '0;
  assign bus.M_ACK     = ((r_state == DATA) && w_sack) ? r_gnt : '0;
  assign bus.BUS_BUSY  = (r_state != IDLE);
  assign bus.ARB_ERR   = w_abort || (w_last_a && !w_mapped) || w_tmo;

endmodule
